// File: rtl/inst_mem_arbiter_if.sv
// Bundle of the fetch, debug and memory-side signals around the
// instruction memory read-port arbiter.
//
// Handshake: a requester raises xxxReq with a stable xxxAddr and holds both
// until it samples xxxGnt=1 in the same cycle; the read is accepted on that
// rising edge. xxxValid is a one-cycle strobe with no back-pressure: xxxData
// is only meaningful while xxxValid=1 and reads 0 otherwise.
interface inst_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  fetchReq;
    logic [ADDR_WIDTH-1:0] fetchAddr;
    logic                  fetchGnt;
    logic                  fetchValid;
    logic [DATA_WIDTH-1:0] fetchData;
    logic                  dbgReq;
    logic [ADDR_WIDTH-1:0] dbgAddr;
    logic                  dbgGnt;
    logic                  dbgValid;
    logic [DATA_WIDTH-1:0] dbgData;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memData;
    logic                  busy;

    // Requesters and the memory side.
    modport master (
        output fetchReq, fetchAddr, dbgReq, dbgAddr, memData,
        input  fetchGnt, fetchValid, fetchData,
        input  dbgGnt, dbgValid, dbgData, memAddr, busy
    );

    // The arbiter.
    modport slave (
        input  fetchReq, fetchAddr, dbgReq, dbgAddr, memData,
        output fetchGnt, fetchValid, fetchData,
        output dbgGnt, dbgValid, dbgData, memAddr, busy
    );
endinterface

// File: rtl/inst_mem_arbiter.sv
// Shares the single instruction-memory read port between the CPU fetch stage
// and a debug/loader port. Fetch normally wins; a starvation counter forces a
// waiting debug request through after STARVE_LIMIT lost cycles. Each issued
// read is tagged with its owner and the tag travels down a MEM_LATENCY deep
// pipeline so the returning memData is routed to the right port.
module inst_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst_n,
    inst_mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic                   fetch_gnt;
    logic                   dbg_gnt;
    logic                   force_dbg;
    logic [CW-1:0]          starve_cnt;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic [MEM_LATENCY-1:0] pipe_vld;
    logic [MEM_LATENCY-1:0] pipe_own;   // 1 = debug owns the read
    logic                   ret_vld;
    logic                   ret_own;

    assign force_dbg = (starve_cnt == LIMIT);

    // One grant per cycle; reset blocks every grant.
    always_comb begin
        fetch_gnt = 1'b0;
        dbg_gnt   = 1'b0;
        if (rst_n) begin
            if (bus.dbgReq && (!bus.fetchReq || force_dbg)) begin
                dbg_gnt = 1'b1;
            end else if (bus.fetchReq) begin
                fetch_gnt = 1'b1;
            end
        end
    end

    // Remember the last driven address so memAddr holds steady when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr_q <= '0;
        end else if (fetch_gnt) begin
            mem_addr_q <= bus.fetchAddr;
        end else if (dbg_gnt) begin
            mem_addr_q <= bus.dbgAddr;
        end
    end

    // Count consecutive cycles a pending debug request loses; saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!bus.dbgReq || dbg_gnt) begin
            starve_cnt <= '0;
        end else if (!force_dbg) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Owner tag pipeline, aligned with the memory read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            pipe_own <= '0;
        end else begin
            pipe_vld[0] <= fetch_gnt | dbg_gnt;
            pipe_own[0] <= dbg_gnt;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end
        end
    end

    assign ret_vld = rst_n & pipe_vld[MEM_LATENCY-1];
    assign ret_own = pipe_own[MEM_LATENCY-1];

    // Drive the memory address and route returning data to its owner.
    always_comb begin
        bus.fetchGnt   = fetch_gnt;
        bus.dbgGnt     = dbg_gnt;
        bus.fetchValid = ret_vld & ~ret_own;
        bus.dbgValid   = ret_vld & ret_own;
        bus.fetchData  = '0;
        bus.dbgData    = '0;
        bus.busy       = rst_n & (|pipe_vld);
        bus.memAddr    = mem_addr_q;
        if (!rst_n) begin
            bus.memAddr = '0;
        end else if (fetch_gnt) begin
            bus.memAddr = bus.fetchAddr;
        end else if (dbg_gnt) begin
            bus.memAddr = bus.dbgAddr;
        end
        if (ret_vld && !ret_own) begin
            bus.fetchData = bus.memData;
        end
        if (ret_vld && ret_own) begin
            bus.dbgData = bus.memData;
        end
    end
endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Directed bench for inst_mem_arbiter: a vector table drives requests and
// checks grants/memAddr in the grant cycle, pushing the expected return
// (owner, data, due cycle) into exp_q; a monitor checks every returned
// strobe, the idle data ports and busy against that queue.
module tb_inst_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 1;
    localparam int EW  = 1 + DW + 16;   // {owner, data, due cycle}

    localparam int G_NONE = 0;
    localparam int G_F    = 1;
    localparam int G_D    = 2;

    typedef struct {
        logic          rst_n;
        logic          freq;
        logic [AW-1:0] faddr;
        logic          dreq;
        logic [AW-1:0] daddr;
        int            gnt;
        logic [DW-1:0] data;
        logic [AW-1:0] maddr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] mem_q = '0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    logic [EW-1:0] exp_q[$];
    vec_t          vecs[$];

    inst_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    inst_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model (one-cycle read) ----------------
    function automatic logic [DW-1:0] mem_lookup(input logic [AW-1:0] a);
        case (a)
            32'h0000_0004: return 32'h8C01_0000;
            32'h0000_0100: return 32'h1111_1111;
            32'h0000_0200: return 32'h2222_2222;
            32'h0000_0300: return 32'h3333_3333;
            default:       return a ^ 32'hDEAD_0000;
        endcase
    endfunction

    always @(posedge clk) mem_q <= mem_lookup(bus.memAddr);
    assign bus.memData = mem_q;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    endtask

    function automatic vec_t v(input logic r, input logic f, input logic [AW-1:0] fa,
                               input logic d, input logic [AW-1:0] da, input int g,
                               input logic [DW-1:0] data, input logic [AW-1:0] ma);
        vec_t t;
        t.rst_n = r; t.freq = f; t.faddr = fa; t.dreq = d; t.daddr = da;
        t.gnt = g; t.data = data; t.maddr = ma;
        return t;
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input vec_t t);
        @(posedge clk);
        #1;
        rst_n         = t.rst_n;
        bus.fetchReq  = t.freq;
        bus.fetchAddr = t.faddr;
        bus.dbgReq    = t.dreq;
        bus.dbgAddr   = t.daddr;
        if (!t.rst_n) exp_q.delete();
        #1;
        check("fetchGnt", DW'(bus.fetchGnt), DW'(t.gnt == G_F));
        check("dbgGnt", DW'(bus.dbgGnt), DW'(t.gnt == G_D));
        check("memAddr", bus.memAddr, t.maddr);
        if (t.gnt != G_NONE)
            exp_q.push_back({(t.gnt == G_D), t.data, 16'(cyc + LAT)});
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic          busy_exp;
        busy_exp = 1'b0;
        foreach (exp_q[i])
            if (int'(exp_q[i][15:0]) - LAT < cyc) busy_exp = 1'b1;
        check("busy", DW'(bus.busy), DW'(busy_exp));
        if (bus.fetchValid || bus.dbgValid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", DW'({bus.dbgValid, bus.fetchValid}), '0);
            end else begin
                e = exp_q.pop_front();
                check("ret_cycle", DW'(cyc), DW'(e[15:0]));
                check("ret_fetchValid", DW'(bus.fetchValid), DW'(!e[EW-1]));
                check("ret_dbgValid", DW'(bus.dbgValid), DW'(e[EW-1]));
                check("ret_owner_data", e[EW-1] ? bus.dbgData : bus.fetchData, e[EW-2:16]);
                check("ret_other_data", e[EW-1] ? bus.fetchData : bus.dbgData, '0);
            end
        end else begin
            check("idle_data", bus.fetchData | bus.dbgData, '0);
            if (exp_q.size() != 0 && int'(exp_q[0][15:0]) <= cyc) begin
                e = exp_q.pop_front();
                check("missing_return", DW'(0), DW'(1));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.fetchReq  = 1'b0;
        bus.fetchAddr = '0;
        bus.dbgReq    = 1'b0;
        bus.dbgAddr   = '0;

        // Reset held 3 cycles with both requesters active: no grants.
        repeat (3) vecs.push_back(v(0, 1, 32'h40, 1, 32'h44, G_NONE, 0, 0));
        // First cycle after release: fetch granted immediately.
        vecs.push_back(v(1, 1, 32'h40, 1, 32'h44, G_F, 32'hDEAD0040, 32'h40));
        vecs.push_back(v(1, 0, 0, 0, 0, G_NONE, 0, 32'h40));
        // Single fetch.
        vecs.push_back(v(1, 1, 32'h4, 0, 0, G_F, 32'h8C010000, 32'h4));
        vecs.push_back(v(1, 0, 0, 0, 0, G_NONE, 0, 32'h4));
        vecs.push_back(v(1, 0, 0, 0, 0, G_NONE, 0, 32'h4));
        // Back-to-back fetches.
        vecs.push_back(v(1, 1, 32'h0, 0, 0, G_F, 32'hDEAD0000, 32'h0));
        vecs.push_back(v(1, 1, 32'h4, 0, 0, G_F, 32'h8C010000, 32'h4));
        vecs.push_back(v(1, 1, 32'h8, 0, 0, G_F, 32'hDEAD0008, 32'h8));
        vecs.push_back(v(1, 1, 32'hC, 0, 0, G_F, 32'hDEAD000C, 32'hC));
        vecs.push_back(v(1, 0, 0, 0, 0, G_NONE, 0, 32'hC));
        // Starvation: F,F,F,F,D repeated twice.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++)
                vecs.push_back(v(1, 1, 32'h40, 1, 32'h44, G_F, 32'hDEAD0040, 32'h40));
            vecs.push_back(v(1, 1, 32'h40, 1, 32'h44, G_D, 32'hDEAD0044, 32'h44));
        end
        vecs.push_back(v(1, 0, 0, 0, 0, G_NONE, 0, 32'h44));
        // Interleaved ownership F,D,F.
        vecs.push_back(v(1, 1, 32'h100, 0, 0, G_F, 32'h11111111, 32'h100));
        vecs.push_back(v(1, 0, 0, 1, 32'h200, G_D, 32'h22222222, 32'h200));
        vecs.push_back(v(1, 1, 32'h300, 0, 0, G_F, 32'h33333333, 32'h300));
        vecs.push_back(v(1, 0, 0, 0, 0, G_NONE, 0, 32'h300));
        // Debug alone is granted by the normal rule.
        vecs.push_back(v(1, 0, 0, 1, 32'h44, G_D, 32'hDEAD0044, 32'h44));
        // Reset right after a debug grant: its return is discarded.
        vecs.push_back(v(1, 0, 0, 1, 32'h200, G_D, 32'h22222222, 32'h200));
        vecs.push_back(v(0, 0, 0, 0, 0, G_NONE, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, G_NONE, 0, 0));
        vecs.push_back(v(1, 1, 32'h4, 0, 0, G_F, 32'h8C010000, 32'h4));
        vecs.push_back(v(1, 0, 0, 0, 0, G_NONE, 0, 32'h4));
        // Address passes through unmodified at the top of the range.
        vecs.push_back(v(1, 1, 32'hFFFFFFFC, 0, 0, G_F, 32'h2152FFFC, 32'hFFFFFFFC));
        vecs.push_back(v(1, 0, 0, 0, 0, G_NONE, 0, 32'hFFFFFFFC));
        vecs.push_back(v(1, 0, 0, 0, 0, G_NONE, 0, 32'hFFFFFFFC));

        foreach (vecs[i]) apply(vecs[i]);

        // Drain with a bounded wait.
        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
        @(posedge clk);
        check("drain_queue_empty", DW'(exp_q.size()), '0);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
